// File: rtl/index_rd_ctrl.sv
// ---------------------------------------------------------------------------
// index_rd_ctrl
//
// Purpose:
//   Reads a job of rd_len words from one bank of the ping-pong sparse-index
//   buffer. Each returned word is Ram_Row rows of Read_Data_Width bits. It is
//   split into Idx_Width-bit indices and streamed out as one index per row
//   per beat, lowest nibble first, over a valid/ready handshake to the PE
//   array. A one-cycle finished pulse marks the end of the job.
//
// Ports:
//   clki, rst        clock, asynchronous active-high reset
//   start            job request, only accepted in IDLE
//   rd_len           number of words to read (0 .. 2^Read_Addr_Width)
//   bank_sel         buffer bank to read, held on ping_pong_read for the job
//   busy, finished   job status (finished is a one-cycle pulse)
//   enout, addrout   buffer read enable / address
//   ping_pong_read   bank select driven to the buffer
//   din              buffer read data, valid the cycle after enout
//   idx_valid/ready  index stream handshake
//   idx_out          lane r = idx_out[r*Idx_Width +: Idx_Width]
//   idx_last         marks the final beat of the job
// ---------------------------------------------------------------------------
module index_rd_ctrl #(
  parameter int Ram_Row         = 16,
  parameter int Read_Data_Width = 64,
  parameter int Read_Addr_Width = 11,
  parameter int Idx_Width       = 4
) (
  input  logic                                 clki,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [Read_Addr_Width:0]             rd_len,
  input  logic                                 bank_sel,
  output logic                                 busy,
  output logic                                 finished,
  output logic                                 enout,
  output logic [Read_Addr_Width-1:0]           addrout,
  output logic                                 ping_pong_read,
  input  logic [Read_Data_Width*Ram_Row-1:0]   din,
  output logic                                 idx_valid,
  input  logic                                 idx_ready,
  output logic [Idx_Width*Ram_Row-1:0]         idx_out,
  output logic                                 idx_last
);

  localparam int Beats = Read_Data_Width / Idx_Width;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD,
    OUT,
    DONE
  } state_t;

  state_t                               r_state;
  logic [Read_Addr_Width:0]             r_len;
  logic [Read_Addr_Width:0]             r_addr;
  logic [BeatW-1:0]                     r_beat;
  logic [Read_Data_Width*Ram_Row-1:0]   r_shift;
  logic                                 r_enout;
  logic [Read_Addr_Width-1:0]           r_addrout;
  logic                                 r_ppRead;
  logic                                 r_valid;
  logic                                 r_finished;

  logic [Read_Data_Width*Ram_Row-1:0]   w_shifted;
  logic [Read_Addr_Width:0]             w_addrNext;
  logic                                 w_lastWord;
  logic                                 w_lastBeat;
  logic                                 w_handshake;

  // The address and length share the extra top bit so that a full-depth
  // job (rd_len = 2^Read_Addr_Width) reaches its final word without wrapping.
  assign w_addrNext  = r_addr + {{Read_Addr_Width{1'b0}}, 1'b1};
  assign w_lastWord  = (r_addr == (r_len - {{Read_Addr_Width{1'b0}}, 1'b1}));
  assign w_lastBeat  = (r_beat == BeatW'(Beats - 1));
  assign w_handshake = r_valid & idx_ready;

  // Every row moves down by one index; the emitted nibble drops off the bottom.
  always_comb begin
    w_shifted = '0;
    for (int r = 0; r < Ram_Row; r++) begin
      w_shifted[r*Read_Data_Width +: Read_Data_Width] =
        {{Idx_Width{1'b0}},
         r_shift[r*Read_Data_Width+Idx_Width +: Read_Data_Width-Idx_Width]};
    end
  end

  // Each lane shows the bottom index of its row, so idx_out only moves on a
  // handshake or a new word load.
  for (genvar g = 0; g < Ram_Row; g++) begin : g_lane
    assign idx_out[g*Idx_Width +: Idx_Width] = r_shift[g*Read_Data_Width +: Idx_Width];
  end

  assign busy           = (r_state != IDLE);
  assign finished       = r_finished;
  assign enout          = r_enout;
  assign addrout        = r_addrout;
  assign ping_pong_read = r_ppRead;
  assign idx_valid      = r_valid;
  assign idx_last       = (r_state == OUT) & w_lastWord & w_lastBeat;

  // Job sequencer: one read (RD), one capture (LD), then Beats handshakes
  // (OUT) per word. Outputs are registered and set on the transition into
  // the state that owns them.
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_addr     <= '0;
      r_beat     <= '0;
      r_shift    <= '0;
      r_enout    <= 1'b0;
      r_addrout  <= '0;
      r_ppRead   <= 1'b0;
      r_valid    <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len    <= rd_len;
            r_ppRead <= bank_sel;
            r_addr   <= '0;
            if (rd_len == '0) begin
              r_finished <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_enout   <= 1'b1;
              r_addrout <= '0;
              r_state   <= RD;
            end
          end
        end
        RD: begin
          r_enout <= 1'b0;
          r_state <= LD;
        end
        LD: begin
          r_shift <= din;
          r_beat  <= '0;
          r_valid <= 1'b1;
          r_state <= OUT;
        end
        OUT: begin
          if (w_handshake) begin
            r_shift <= w_shifted;
            r_beat  <= r_beat + 1'b1;
            if (w_lastBeat) begin
              r_valid <= 1'b0;
              if (w_lastWord) begin
                r_finished <= 1'b1;
                r_state    <= DONE;
              end else begin
                r_addr    <= w_addrNext;
                r_addrout <= w_addrNext[Read_Addr_Width-1:0];
                r_enout   <= 1'b1;
                r_state   <= RD;
              end
            end
          end
        end
        DONE: begin
          r_finished <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_index_rd_ctrl.sv
// Self-checking bench for index_rd_ctrl. A behavioural buffer returns a known
// word per (bank, address); every expected index beat is queued when a job is
// started and compared against the stream as handshakes occur.
module tb_index_rd_ctrl;

  localparam int RamRow = 16;
  localparam int DataW  = 64;
  localparam int AddrW  = 11;
  localparam int IdxW   = 4;
  localparam int Beats  = DataW / IdxW;

  typedef struct {
    logic [IdxW*RamRow-1:0] idx;
    logic                   last;
  } beat_t;

  typedef struct {
    int             cyc;
    logic [AddrW-1:0] addr;
  } rd_t;

  logic                      clki = 1'b0;
  logic                      rst;
  logic                      start;
  logic [AddrW:0]            rd_len;
  logic                      bank_sel;
  logic                      busy;
  logic                      finished;
  logic                      enout;
  logic [AddrW-1:0]          addrout;
  logic                      ping_pong_read;
  logic [DataW*RamRow-1:0]   din;
  logic                      idx_valid;
  logic                      idx_ready;
  logic [IdxW*RamRow-1:0]    idx_out;
  logic                      idx_last;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int startCyc = 0;
  int finCount = 0;
  int finBase  = 0;
  int finCyc   = -1;
  int hsCount  = 0;
  int validSeen = 0;
  logic expBank = 1'b0;
  logic toggleReady = 1'b0;

  beat_t sb[$];
  rd_t   enQ[$];

  logic                   prevStall = 1'b0;
  logic [IdxW*RamRow-1:0] prevOut;
  logic                   prevLast;

  index_rd_ctrl #(
    .Ram_Row(RamRow), .Read_Data_Width(DataW),
    .Read_Addr_Width(AddrW), .Idx_Width(IdxW)
  ) dut (
    .clki(clki), .rst(rst), .start(start), .rd_len(rd_len), .bank_sel(bank_sel),
    .busy(busy), .finished(finished), .enout(enout), .addrout(addrout),
    .ping_pong_read(ping_pong_read), .din(din), .idx_valid(idx_valid),
    .idx_ready(idx_ready), .idx_out(idx_out), .idx_last(idx_last)
  );

  always #5 clki = ~clki;

  always @(posedge clki) cyc++;

  // Contents of the buffer: the first two bank-0 words follow the basic-job
  // pattern, everything else is a scrambled function of bank/address/row.
  function automatic logic [DataW-1:0] rowWord(input logic bank, input int addr, input int row);
    logic [63:0] key;
    if (!bank && addr == 0) return 64'h0123456789ABCDEF + 64'(row);
    if (!bank && addr == 1) return {16{4'h5}};
    key = 64'(addr * 16 + row + 1 + (bank ? 100000 : 0));
    return (key * 64'h9E3779B97F4A7C15) ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  function automatic logic [DataW*RamRow-1:0] buildWord(input logic bank, input int addr);
    logic [DataW*RamRow-1:0] w;
    for (int r = 0; r < RamRow; r++) w[r*DataW +: DataW] = rowWord(bank, addr, r);
    return w;
  endfunction

  // Synchronous buffer model: data for a read appears the cycle after enout;
  // all other cycles carry junk the DUT must not capture.
  always @(posedge clki) begin
    if (enout) din <= buildWord(ping_pong_read, int'(addrout));
    else for (int i = 0; i < DataW*RamRow/32; i++) din[i*32 +: 32] <= $urandom;
  end

  always @(posedge clki) begin
    #1;
    if (toggleReady) idx_ready = ~idx_ready;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Observe everything at the negedge, where inputs and outputs are settled.
  always @(negedge clki) begin
    beat_t e;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (enout) begin
        enQ.push_back('{cyc: cyc - startCyc, addr: addrout});
        checkOutput("pp_read", 64'(ping_pong_read), 64'(expBank));
      end
      if (finished) begin
        finCount++;
        finCyc = cyc - startCyc;
      end
      if (prevStall) begin
        checkOutput("hold_valid", 64'(idx_valid), 64'd1);
        checkOutput("hold_out", idx_out, prevOut);
        checkOutput("hold_last", 64'(idx_last), 64'(prevLast));
      end
      if (idx_valid) validSeen++;
      if (idx_valid && idx_ready) begin
        hsCount++;
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("idx_out", idx_out, e.idx);
          checkOutput("idx_last", 64'(idx_last), 64'(e.last));
        end
      end
      prevStall = idx_valid && !idx_ready;
      prevOut   = idx_out;
      prevLast  = idx_last;
    end
  end

  // Pulse start for one cycle. A tracked start resets the per-job records
  // and queues every beat the job must produce; an ignored start does not.
  task automatic applyStimulus(input int len, input logic bank, input bit ignored);
    beat_t b;
    logic [DataW-1:0] rw;
    @(posedge clki);
    #1;
    start    = 1'b1;
    rd_len   = (AddrW+1)'(len);
    bank_sel = bank;
    if (!ignored) begin
      startCyc  = cyc;
      finBase   = finCount;
      finCyc    = -1;
      hsCount   = 0;
      validSeen = 0;
      expBank   = bank;
      enQ.delete();
      for (int a = 0; a < len; a++) begin
        for (int k = 0; k < Beats; k++) begin
          for (int r = 0; r < RamRow; r++) begin
            rw = rowWord(bank, a, r);
            b.idx[r*IdxW +: IdxW] = rw[k*IdxW +: IdxW];
          end
          b.last = (a == len - 1) && (k == Beats - 1);
          sb.push_back(b);
        end
      end
    end
    @(posedge clki);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (finCount == finBase && n < budget) begin
      @(posedge clki);
      n++;
    end
    if (finCount == finBase) checkOutput({tag, "_timeout"}, 64'd1, 64'd0);
    repeat (4) @(posedge clki);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_finished"}, 64'(finished), 64'd0);
    checkOutput({tag, "_enout"}, 64'(enout), 64'd0);
    checkOutput({tag, "_addrout"}, 64'(addrout), 64'd0);
    checkOutput({tag, "_pp_read"}, 64'(ping_pong_read), 64'd0);
    checkOutput({tag, "_valid"}, 64'(idx_valid), 64'd0);
    checkOutput({tag, "_idx_out"}, idx_out, 64'd0);
    checkOutput({tag, "_last"}, 64'(idx_last), 64'd0);
  endtask

  initial begin
    int n;
    int finHold;
    rst = 1'b1; start = 1'b0; rd_len = '0; bank_sel = 1'b0; idx_ready = 1'b1;
    repeat (3) @(posedge clki);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;

    // Basic job: two words from bank 0, consumer always ready.
    $display("[TB] basic job");
    applyStimulus(2, 1'b0, 1'b0);
    waitDone("basic", 200);
    checkOutput("basic_rd_count", 64'(enQ.size()), 64'd2);
    if (enQ.size() == 2) begin
      checkOutput("basic_rd0_cyc", 64'(enQ[0].cyc), 64'd1);
      checkOutput("basic_rd0_addr", 64'(enQ[0].addr), 64'd0);
      checkOutput("basic_rd1_cyc", 64'(enQ[1].cyc), 64'd19);
      checkOutput("basic_rd1_addr", 64'(enQ[1].addr), 64'd1);
    end
    checkOutput("basic_beats", 64'(hsCount), 64'd32);
    checkOutput("basic_fin_count", 64'(finCount - finBase), 64'd1);
    checkOutput("basic_fin_cyc", 64'(finCyc), 64'd37);
    checkOutput("basic_sb_left", 64'(sb.size()), 64'd0);

    // Backpressure: ready alternates every cycle for a single word.
    $display("[TB] backpressure");
    toggleReady = 1'b1;
    applyStimulus(1, 1'b0, 1'b0);
    waitDone("bp", 200);
    toggleReady = 1'b0;
    @(posedge clki);
    #2;
    idx_ready = 1'b1;
    checkOutput("bp_beats", 64'(hsCount), 64'd16);
    checkOutput("bp_rd_count", 64'(enQ.size()), 64'd1);
    checkOutput("bp_fin_count", 64'(finCount - finBase), 64'd1);
    checkOutput("bp_sb_left", 64'(sb.size()), 64'd0);

    // Empty job: straight to DONE.
    $display("[TB] empty job");
    applyStimulus(0, 1'b0, 1'b0);
    @(negedge clki);
    checkOutput("empty_busy_c1", 64'(busy), 64'd1);
    checkOutput("empty_fin_c1", 64'(finished), 64'd1);
    @(negedge clki);
    checkOutput("empty_busy_c2", 64'(busy), 64'd0);
    checkOutput("empty_fin_c2", 64'(finished), 64'd0);
    repeat (4) @(posedge clki);
    checkOutput("empty_fin_cyc", 64'(finCyc), 64'd1);
    checkOutput("empty_rd_count", 64'(enQ.size()), 64'd0);
    checkOutput("empty_valid", 64'(validSeen), 64'd0);

    // Bank 1 with a second start issued mid-job that must be ignored.
    $display("[TB] bank select and ignored start");
    applyStimulus(3, 1'b1, 1'b0);
    repeat (10) @(posedge clki);
    applyStimulus(1, 1'b0, 1'b1);
    waitDone("bank", 300);
    checkOutput("bank_rd_count", 64'(enQ.size()), 64'd3);
    for (int i = 0; i < enQ.size(); i++) checkOutput("bank_rd_addr", 64'(enQ[i].addr), 64'(i));
    checkOutput("bank_beats", 64'(hsCount), 64'd48);
    checkOutput("bank_fin_count", 64'(finCount - finBase), 64'd1);
    checkOutput("bank_pp_after", 64'(ping_pong_read), 64'd1);
    checkOutput("bank_sb_left", 64'(sb.size()), 64'd0);

    // Reset in the middle of word 1, at beat 7.
    $display("[TB] reset mid-job");
    applyStimulus(2, 1'b0, 1'b0);
    n = 0;
    while (hsCount < Beats + 7 && n < 200) begin
      @(posedge clki);
      #2;
      n++;
    end
    checkOutput("rstjob_reach_beat", 64'(hsCount), 64'(Beats + 7));
    rst = 1'b1;
    #1;
    checkResetOutputs("rst_async");
    sb.delete();
    finHold = finCount;
    repeat (3) @(posedge clki);
    checkOutput("rst_no_finish", 64'(finCount), 64'(finHold));
    #1;
    rst = 1'b0;
    applyStimulus(1, 1'b0, 1'b0);
    waitDone("postrst", 200);
    checkOutput("postrst_rd_count", 64'(enQ.size()), 64'd1);
    if (enQ.size() == 1) checkOutput("postrst_rd_addr", 64'(enQ[0].addr), 64'd0);
    checkOutput("postrst_beats", 64'(hsCount), 64'd16);
    checkOutput("postrst_sb_left", 64'(sb.size()), 64'd0);

    // Full depth: every address of the buffer.
    $display("[TB] full depth");
    applyStimulus(2048, 1'b0, 1'b0);
    waitDone("full", 40000);
    checkOutput("full_rd_count", 64'(enQ.size()), 64'd2048);
    for (int i = 0; i < enQ.size(); i++) begin
      if (enQ[i].addr !== AddrW'(i)) checkOutput("full_rd_addr", 64'(enQ[i].addr), 64'(i));
    end
    if (enQ.size() > 0) checkOutput("full_last_addr", 64'(enQ[enQ.size()-1].addr), 64'd2047);
    checkOutput("full_beats", 64'(hsCount), 64'd32768);
    checkOutput("full_fin_count", 64'(finCount - finBase), 64'd1);
    checkOutput("full_sb_left", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
